// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: operand width, FSM states
// and the two's-complement magnitude/negate helpers.
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    // |0x80000000| stays 0x80000000, which is correct when read as unsigned.
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? negate(x) : x;
    endfunction

endpackage

// File: rtl/add_sub.sv
// Shared adder/subtractor: sum = a + b, or a - b when sub is high.
module add_sub #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    assign sum = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder; the sign of the difference selects the quotient bit.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, bit_in};

    add_sub #(.W(WIDTH + 1)) u_sub (
        .a   (shifted),
        .b   ({1'b0, divisor}),
        .sub (1'b1),
        .sum (diff)
    );

    // Non-negative difference means the divisor fits: take it and emit a 1.
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: magnitudes are divided by a restoring loop of
// WIDTH steps, and the quotient sign is applied on the completion edge.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t           state, state_next;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] divisor;
    logic             sign_q;
    logic             div_zero;
    logic             zero_wait;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic             operand_b_zero;

    assign operand_b_zero = (data_operandB == '0);
    assign busy           = (state == ST_RUN);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .bit_in   (q[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero divisor skips the loop but dwells one extra cycle in DONE so its
    // completion lands two edges after the start.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ctrl_div) begin
                    state_next = operand_b_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (counter == CNT_W'(WIDTH - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = zero_wait ? ST_DONE : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter        <= '0;
            rem            <= '0;
            q              <= '0;
            divisor        <= '0;
            sign_q         <= 1'b0;
            div_zero       <= 1'b0;
            zero_wait      <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctrl_div) begin
                        q         <= WIDTH'(abs_val(DIV_WIDTH'(data_operandA)));
                        divisor   <= WIDTH'(abs_val(DIV_WIDTH'(data_operandB)));
                        sign_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        rem       <= '0;
                        counter   <= '0;
                        div_zero  <= operand_b_zero;
                        zero_wait <= operand_b_zero;
                    end
                end
                ST_RUN: begin
                    rem     <= rem_next;
                    q       <= {q[WIDTH-2:0], q_bit};
                    counter <= counter + 1'b1;
                end
                ST_DONE: begin
                    if (zero_wait) begin
                        zero_wait <= 1'b0;
                    end else begin
                        data_resultRDY <= 1'b1;
                        data_exception <= div_zero;
                        if (div_zero) begin
                            data_result <= '0;
                        end else begin
                            data_result <= sign_q ? WIDTH'(negate(DIV_WIDTH'(q))) : q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus hand sequences,
// with a scoreboard queue checked whenever a ready pulse appears.
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_div = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_count = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          edge_no;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;
    vec_t vecs[$];

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            sb_t e;
            rdy_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got result 0x%08h expected no pulse (cycle %0d)",
                         data_result, cyc);
            end else begin
                e = sb.pop_front();
                check("result", data_result, e.res);
                check("exception", 32'(data_exception), 32'(e.exc));
                check("latency_edge", 32'(cyc), 32'(e.edge_no));
            end
        end
    end

    // Call at a negedge: drives the start pulse across the next rising edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic expect_it, input logic [31:0] res, input logic exc);
        sb_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_div      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        if (expect_it) begin
            e.res     = res;
            e.exc     = exc;
            e.edge_no = cyc + ((b == 32'd0) ? 2 : 33);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int bc;
        int t;
        int rc;

        vecs.push_back('{32'd100,       32'd7,         32'd14,        1'b0});
        vecs.push_back('{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  1'b0});
        vecs.push_back('{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  1'b0});
        vecs.push_back('{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        1'b0});
        vecs.push_back('{32'd5,         32'd0,         32'd0,         1'b1});
        vecs.push_back('{32'd9,         32'd3,         32'd3,         1'b0});
        vecs.push_back('{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0});
        vecs.push_back('{32'h80000000,  32'd1,         32'h80000000,  1'b0});
        vecs.push_back('{32'd7,         32'd100,       32'd0,         1'b0});
        vecs.push_back('{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0});
        vecs.push_back('{32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  1'b0});
        vecs.push_back('{32'h80000000,  32'h80000000,  32'd1,         1'b0});
        vecs.push_back('{32'd1,         32'h80000000,  32'd0,         1'b0});
        vecs.push_back('{32'hFFFFFFFF,  32'd0,         32'd0,         1'b1});

        repeat (3) @(negedge clock);
        check("reset_result", data_result, 32'd0);
        check("reset_exception", 32'(data_exception), 32'd0);
        check("reset_rdy", 32'(data_resultRDY), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Basic divide with busy-window length.
        @(negedge clock);
        start(32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            if (busy) bc++;
            if (sb.size() == 0) break;
        end
        check("busy_cycles", 32'(bc), 32'd32);
        drain(10);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            start(vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].exc);
            drain(60);
        end

        // Start ignored while running, then a back-to-back start in the RDY cycle.
        rc = rdy_count;
        @(negedge clock);
        start(32'd1000, 32'd10, 1'b1, 32'd100, 1'b0);
        repeat (10) @(negedge clock);
        data_operandA = 32'd7;
        data_operandB = 32'd7;
        ctrl_div      = 1'b1;
        @(negedge clock);
        ctrl_div = 1'b0;
        t = 0;
        while (!data_resultRDY && t < 60) begin
            @(negedge clock);
            t++;
        end
        if (data_resultRDY) begin
            start(32'd21, 32'd4, 1'b1, 32'd5, 1'b0);
        end else begin
            checks++;
            errors++;
            $display("FAIL wait_rdy: got no ready pulse expected one within 60 cycles");
        end
        drain(60);
        check("b2b_rdy_count", 32'(rdy_count - rc), 32'd2);

        // Asynchronous reset in the middle of a division.
        @(negedge clock);
        start(32'd1000, 32'd10, 1'b0, 32'd0, 1'b0);
        repeat (15) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", data_result, 32'd0);
        check("abort_exception", 32'(data_exception), 32'd0);
        check("abort_rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rc = rdy_count;
        repeat (40) @(negedge clock);
        #1;
        check("abort_no_rdy", 32'(rdy_count - rc), 32'd0);
        @(negedge clock);
        start(32'd8, 32'd2, 1'b1, 32'd4, 1'b0);
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
